ins_loader: RTL and testbench

//   Instruction-memory writer that sits opposite ins_fetch: ins_fetch reads a word at base_in+pc and

---
 rtl/ins_loader.sv | 210 +++++++++++++++++++++
 tb/tb_ins_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_loader.sv
// ----------------------------------------------------------------------------
// ins_loader
//
// Instruction-memory writer, the counterpart of ins_fetch. Field tuples
// (opcode, rd, funct3, rs1, rs2, funct7) are packed into 32-bit instruction
// words. The words pass through a small elastic FIFO and are then written
// sequentially to word addresses base, base+1, ... in instruction memory.
//
// Optional feature macro: INS_LOADER_CHKSUM_EN
//   When this macro is defined, the module has an extra output, checksum[31:0].
//   The checksum is the XOR of every acknowledged write word in the current
//   session. It is cleared when a start is accepted and is valid when done
//   pulses. When the macro is not defined, there is no checksum port and no
//   checksum logic.
//
// Parameters
//   FIFO_DEPTH  packed-word entries between the field input and the memory
//               port (power of 2, >= 2)
//   MAX_WORDS   upper bound on words per session; a larger len_in is clamped
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          begin a session (sampled only in IDLE)
//   base_in        word base address, latched on accepted start
//   len_in         words to load, latched (clamped) on accepted start
//   in_valid       field tuple valid
//   in_ready       field tuple accepted this cycle when in_valid is high
//   opcode..funct7 instruction fields
//   mem_we         write request, held until mem_ack
//   mem_addr       word address of the write (base + words_written)
//   mem_wdata      packed word at the FIFO head
//   mem_ack        memory accepted the current write
//   busy           high while loading
//   done           one-cycle pulse at session end
//   words_written  words acknowledged in the current/last session
// ----------------------------------------------------------------------------
module ins_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_in,
    input  logic [15:0] len_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_written
`ifdef INS_LOADER_CHKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]      base_reg;
    logic [15:0]      len_reg;
    logic [15:0]      accepted_reg;
    logic [15:0]      written_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [31:0]      fifo_mem [FIFO_DEPTH];

    logic [15:0] len_clamped;
    logic [31:0] packed_word;
    logic        start_ok;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        last_ack;

    // The packing is the exact inverse of the field split done by ins_fetch.
    assign packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
    assign len_clamped = (len_in > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : len_in;

    assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign start_ok   = (state_reg == S_IDLE) && start;

    // Stop accepting tuples once len tuples are in. Because of this limit, the
    // FIFO drains to empty by the time the last word is acknowledged.
    assign in_ready = (state_reg == S_LOAD) && !fifo_full && (accepted_reg < len_reg);
    assign push     = in_valid && in_ready;

    // The write request comes from the registered occupancy. A word therefore
    // appears on the port one cycle after its push; there is no bypass path.
    assign mem_we    = (state_reg == S_LOAD) && !fifo_empty;
    assign pop       = mem_we && mem_ack;
    assign last_ack  = pop && ((written_reg + 16'd1) == len_reg);
    assign mem_addr  = base_reg + {16'd0, written_reg};
    assign mem_wdata = mem_we ? fifo_mem[rd_ptr_reg] : 32'd0;

    assign busy          = (state_reg == S_LOAD);
    assign done          = (state_reg == S_DONE);
    assign words_written = written_reg;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (len_clamped == 16'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_ack) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Session registers and FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg     <= '0;
            len_reg      <= '0;
            accepted_reg <= '0;
            written_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            // Only one of these can be true in a given cycle: start_ok is
            // valid only in IDLE, and push/pop are valid only in LOAD.
            if (start_ok) begin
                base_reg     <= base_in;
                len_reg      <= len_clamped;
                accepted_reg <= '0;
                written_reg  <= '0;
            end
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                accepted_reg <= accepted_reg + 16'd1;
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                written_reg <= written_reg + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The FIFO storage is not reset. mem_wdata is gated by mem_we, so stale
    // entries are never visible on the port.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= packed_word;
        end
    end

`ifdef INS_LOADER_CHKSUM_EN
    logic [31:0] checksum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (start_ok) begin
            checksum_reg <= '0;
        end else if (pop) begin
            checksum_reg <= checksum_reg ^ mem_wdata;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_ins_loader.sv
// ----------------------------------------------------------------------------
// tb_ins_loader
//
// Testbench for ins_loader. It combines three kinds of stimulus:
//   - a table of field tuples with hand-computed packed words,
//   - hand-written multi-cycle sequences,
//   - randomized sessions checked against a transaction-level model. The
//     model tracks counts of pushed and written words and a queue of pending
//     packed words.
// ----------------------------------------------------------------------------
module tb_ins_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_in;
    logic [15:0] len_in;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  f_op;
    logic [4:0]  f_rd;
    logic [2:0]  f_f3;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [6:0]  f_f7;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic [15:0] words_written;
`ifdef INS_LOADER_CHKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    ins_loader #(
        .FIFO_DEPTH (4),
        .MAX_WORDS  (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_in       (base_in),
        .len_in        (len_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (f_op),
        .rd            (f_rd),
        .funct3        (f_f3),
        .rs1           (f_rs1),
        .rs2           (f_rs2),
        .funct7        (f_f7),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
`ifdef INS_LOADER_CHKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    // ------------------------------------------------------------------
    // Vector table: field tuple -> hand-computed instruction word
    // ------------------------------------------------------------------
    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vtab [NV];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_active;
    bit          m_done;
    logic [31:0] m_base;
    int          m_len;
    int          m_pushed;
    int          m_written;
    logic [31:0] m_chk;
    logic [31:0] m_q [$];

    // Observed write log and counters
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    int          done_cnt;
    int          obs_push;

    function automatic logic [31:0] pack(input logic [6:0] op, input logic [4:0] rdv,
                                         input logic [2:0] f3, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [6:0] f7);
        return {f7, r2, r1, f3, rdv, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_done    = 1'b0;
        m_base    = '0;
        m_len     = 0;
        m_pushed  = 0;
        m_written = 0;
        m_chk     = '0;
        m_q.delete();
    endtask

    // Compare the outputs against the model, advance the model by one
    // clock edge using the current inputs, then step to just after the edge.
    task automatic tick();
        logic        exp_we;
        logic        exp_rdy;
        logic [31:0] w;
        exp_we  = m_active && (m_q.size() != 0);
        exp_rdy = m_active && ((m_pushed - m_written) < 4) && (m_pushed < m_len);
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("words_written", 32'(words_written), 32'(m_written));
        if (exp_we) begin
            chk("mem_addr", mem_addr, m_base + 32'(m_written));
            chk("mem_wdata", mem_wdata, m_q[0]);
        end
`ifdef INS_LOADER_CHKSUM_EN
        if (m_done) chk("checksum", checksum, m_chk);
`endif
        if (done) done_cnt++;
        if (in_valid && in_ready) obs_push++;
        if (!rst && mem_we && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end

        if (rst) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_base    = base_in;
                m_len     = (int'(len_in) > 64) ? 64 : int'(len_in);
                m_pushed  = 0;
                m_written = 0;
                m_chk     = '0;
                m_q.delete();
                if (m_len == 0) m_done = 1'b1;
                else            m_active = 1'b1;
            end
        end else begin
            if (exp_we && mem_ack) begin
                w = m_q.pop_front();
                m_chk = m_chk ^ w;
                m_written++;
            end
            if (in_valid && exp_rdy) begin
                m_q.push_back(pack(f_op, f_rd, f_f3, f_rs1, f_rs2, f_f7));
                m_pushed++;
            end
            if (m_written == m_len) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // src: 0 = random fields, 1 = next table entry, 2 = hold current fields
    task automatic drive_fields(input int src);
        int idx;
        if (src == 0) begin
            f_op  = 7'($urandom);
            f_rd  = 5'($urandom);
            f_f3  = 3'($urandom);
            f_rs1 = 5'($urandom);
            f_rs2 = 5'($urandom);
            f_f7  = 7'($urandom);
        end else if (src == 1) begin
            idx   = m_pushed % NV;
            f_op  = vtab[idx].op;
            f_rd  = vtab[idx].rd;
            f_f3  = vtab[idx].f3;
            f_rs1 = vtab[idx].rs1;
            f_rs2 = vtab[idx].rs2;
            f_f7  = vtab[idx].f7;
        end
    endtask

    task automatic start_session(input logic [31:0] b, input logic [15:0] l);
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
        base_in  = b;
        len_in   = l;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic finish_session(input int vpct, input int apct, input int src);
        int budget;
        budget = 0;
        while ((m_active || m_done) && budget < 3000) begin
            in_valid = ($urandom_range(0, 99) < vpct);
            mem_ack  = ($urandom_range(0, 99) < apct);
            base_in  = $urandom;
            len_in   = 16'($urandom);
            drive_fields(src);
            tick();
            budget++;
        end
        n_vec++;
        if (m_active || m_done) begin
            n_bad++;
            $display("FAIL session_timeout: still active after %0d cycles, required idle", budget);
        end
        in_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic run_session(input logic [31:0] b, input logic [15:0] l,
                               input int vpct, input int apct, input int src);
        start_session(b, l);
        finish_session(vpct, apct, src);
    endtask

    initial begin
        vtab[0]  = '{7'h01, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h0000_0001};
        vtab[1]  = '{7'h02, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h0000_0002};
        vtab[2]  = '{7'h04, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h0000_0004};
        vtab[3]  = '{7'h33, 5'd1,  3'd0, 5'd2,  5'd3,  7'h00, 32'h0031_00B3};
        vtab[4]  = '{7'h13, 5'd1,  3'd0, 5'd0,  5'd5,  7'h00, 32'h0050_0093};
        vtab[5]  = '{7'h00, 5'd31, 3'd0, 5'd0,  5'd0,  7'h00, 32'h0000_0F80};
        vtab[6]  = '{7'h00, 5'd0,  3'd7, 5'd0,  5'd0,  7'h00, 32'h0000_7000};
        vtab[7]  = '{7'h00, 5'd0,  3'd0, 5'd31, 5'd0,  7'h00, 32'h000F_8000};
        vtab[8]  = '{7'h00, 5'd0,  3'd0, 5'd0,  5'd31, 7'h00, 32'h01F0_0000};
        vtab[9]  = '{7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h7F, 32'hFE00_0000};
        vtab[10] = '{7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 32'hFFFF_FFFF};
        vtab[11] = '{7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h20, 32'h4020_81B3};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        base_in = '0; len_in = '0;
        f_op = '0; f_rd = '0; f_f3 = '0; f_rs1 = '0; f_rs2 = '0; f_f7 = '0;
        done_cnt = 0; obs_push = 0;
        model_reset();

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_words_written", 32'(words_written), 32'd0);
`ifdef INS_LOADER_CHKSUM_EN
        chk("rst_checksum", checksum, 32'd0);
`endif
        rst = 1'b0;

        // Table-driven packing: every entry written in order
        run_session(32'h0000_0200, 16'(NV), 100, 100, 1);
        chk("tbl_count", 32'(log_data.size()), 32'(NV));
        for (int i = 0; i < NV && i < log_data.size(); i++) begin
            chk($sformatf("tbl_word[%0d]", i), log_data[i], vtab[i].exp);
            chk($sformatf("tbl_addr[%0d]", i), log_addr[i], 32'h200 + 32'(i));
        end
        chk("tbl_done_cnt", 32'(done_cnt), 32'd1);

        // Words 0x1, 0x2, 0x4
        run_session(32'h0000_0500, 16'd3, 100, 100, 1);
        chk("chk3_count", 32'(log_data.size()), 32'd3);
`ifdef INS_LOADER_CHKSUM_EN
        chk("checksum_final", checksum, 32'h0000_0007);
`endif

        // Basic session: base 0x100, three identical tuples, ack always high
        f_op = 7'h33; f_rd = 5'd1; f_f3 = 3'd0; f_rs1 = 5'd2; f_rs2 = 5'd3; f_f7 = 7'h00;
        run_session(32'h0000_0100, 16'd3, 100, 100, 2);
        chk("basic_count", 32'(log_data.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_data.size(); i++) begin
            chk($sformatf("basic_word[%0d]", i), log_data[i], 32'h0031_00B3);
            chk($sformatf("basic_addr[%0d]", i), log_addr[i], 32'h100 + 32'(i));
        end
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_ww_final", 32'(words_written), 32'd3);

        // Backpressure: ack low while in_valid stays high
        start_session(32'h0000_0300, 16'd8);
        obs_push = 0;
        in_valid = 1'b1;
        mem_ack  = 1'b0;
        repeat (6) begin
            drive_fields(0);
            tick();
        end
        chk("bp_pushes", 32'(obs_push), 32'd4);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_mem_we_held", 32'(mem_we), 32'd1);
        chk("bp_addr_held", mem_addr, 32'h300);
        finish_session(100, 100, 0);
        chk("bp_count", 32'(log_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            chk($sformatf("bp_addr[%0d]", i), log_addr[i], 32'h300 + 32'(i));
        end

        // Zero length: done without any write
        run_session(32'h0000_0040, 16'd0, 100, 100, 0);
        chk("len0_done_cnt", 32'(done_cnt), 32'd1);
        chk("len0_writes", 32'(log_data.size()), 32'd0);

        // Clamp to 64 words, address wraps past 0xFFFFFFFF
        run_session(32'hFFFF_FFFE, 16'd100, 80, 80, 0);
        chk("clamp_count", 32'(log_data.size()), 32'd64);
        if (log_addr.size() >= 64) begin
            chk("wrap_addr2", log_addr[2], 32'h0000_0000);
            chk("wrap_addr63", log_addr[63], 32'h0000_003D);
        end
        chk("clamp_ww", 32'(words_written), 32'd64);

        // Reset in the middle of a session
        start_session(32'h0000_0400, 16'd4);
        in_valid = 1'b1;
        mem_ack  = 1'b1;
        for (int c = 0; c < 50 && m_written < 2; c++) begin
            drive_fields(0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_ww", 32'(words_written), 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        run_session(32'h0000_0600, 16'd5, 100, 100, 0);
        chk("postrst_count", 32'(log_data.size()), 32'd5);
        if (log_addr.size() > 0) chk("postrst_addr0", log_addr[0], 32'h600);

        // Randomized sessions
        for (int s = 0; s < 20; s++) begin
            logic [15:0] l;
            int          exp_n;
            l = (s % 5 == 4) ? 16'($urandom_range(60, 90)) : 16'($urandom_range(0, 20));
            exp_n = (int'(l) > 64) ? 64 : int'(l);
            run_session($urandom, l, $urandom_range(30, 100), $urandom_range(30, 100), 0);
            chk($sformatf("rand%0d_count", s), 32'(log_data.size()), 32'(exp_n));
            chk($sformatf("rand%0d_done_cnt", s), 32'(done_cnt), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
